muldiv_hilo_64: RTL and testbench
=================================

Name: muldiv_hilo_64

Overview:
- Iterative 32-bit multiply/divide unit with the HI/LO register pair for the EXP6 MIPS datapath.
- Holds a 64-bit {HI,LO} result that feeds the 64-bit 2:1 result-select mux directly downstream. The mux chooses between this block's output and the alternate 64-bit source.
- Executes mult/multu/div/divu over multiple cycles with a start/busy/done handshake.
- Also supports direct mthi/mtlo writes.

Parameters:
- DW, 32, operand width; HI and LO are each DW bits wide and hilo is 2*DW bits.
- ITER, 32, iterations per operation; must equal DW.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation: 00 multu, 01 mult, 10 divu, 11 div.
- a  input  DW  multiplicand or dividend (rs).
- b  input  DW  multiplier or divisor (rt).
- hi_we  input  1  mthi write enable.
- lo_we  input  1  mtlo write enable.
- wdata  input  DW  data for mthi/mtlo.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when hilo is updated by an operation.
- hilo  output  2*DW  {HI,LO}; feeds the downstream 64-bit select mux.

Behaviour:
- Reset (async, active-high, mid-operation included):
  - FSM goes to IDLE; busy=0, done=0, hilo=0.
  - Any in-flight operation is aborted with no partial result written.
  - On rst release, start is honoured at the first rising edge.
- FSM states: IDLE, RUN, FIN.
  - IDLE -> RUN on start=1 at edge N. The block latches op, |a|, |b| and the sign flags: product/quotient sign = a[31]^b[31] for signed ops; remainder sign = a[31].
  - RUN: one shift-add step (multiply) or one restoring shift-subtract step (divide) per edge. An iteration counter counts 0..ITER-1.
  - At the edge after the last iteration (edge N+ITER): sign correction is applied, hilo is written, and the FSM goes to FIN.
  - FIN -> IDLE unconditionally on the next edge.
- Handshake timing:
  - busy=1 from after edge N through the cycle in which hilo is written.
  - busy=1 in RUN; done=1 only in FIN; busy=0 in FIN.
  - Latency: start at edge N gives a new hilo visible after edge N+ITER and done high for exactly the cycle following edge N+ITER.
  - A new start is accepted in IDLE only; start is ignored in RUN and FIN.
- Results:
  - mult/multu: hilo = full 2*DW-bit product (signed or unsigned).
  - div/divu: LO = quotient, HI = remainder. Signed results truncate toward zero; the remainder takes the dividend's sign.
  - Divide by zero (divu or div): LO = all ones, HI = a. The unit still takes the full latency.
  - div with a = 0x80000000 and b = 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- mthi/mtlo:
  - In IDLE, hi_we writes wdata into HI and lo_we writes wdata into LO at the edge; both may be set in the same cycle.
  - These writes are ignored in RUN and FIN.
  - If start and hi_we/lo_we are asserted in the same IDLE cycle, start wins and the writes are dropped.
  - done is not pulsed for these writes.
- hilo holds its value at all times except during a result write, an mthi/mtlo write, or reset.

Optional Feature:
- Macro: MULDIV_EARLY_ZERO_EN.
- Defined: if start is accepted with a multiply and a==0 or b==0, or with a divide and a==0 and b!=0, the FSM goes IDLE -> FIN directly.
  - hilo is written to 0 at edge N+1.
  - done is pulsed in the cycle after edge N+1.
  - busy is high for exactly one cycle.
- Undefined: all operations take the fixed ITER-cycle latency. No early-exit comparators are synthesized.

Test Plan:
- multu a=0xFFFFFFFF, b=0xFFFFFFFF, start at edge N -> busy high for 32 cycles; done pulses one cycle after edge N+32; hilo=0xFFFFFFFE_00000001.
- mult a=0xFFFFFFFD (-3), b=7 -> hilo=0xFFFFFFFF_FFFFFFEB (-21). div a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- divu a=100, b=0 -> LO=0xFFFFFFFF, HI=100. div a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- start pulsed again and hi_we=1 with wdata=0x1234 during RUN -> both ignored; the first result is unaffected. After return to IDLE, hi_we=1 with wdata=0x1234 -> HI=0x1234, LO unchanged, no done pulse.
- rst asserted asynchronously mid-RUN (cycle 10 of 32) -> busy, done and hilo go to 0 immediately; no done pulse follows. A start on the first edge after release completes normally.
- With MULDIV_EARLY_ZERO_EN: multu a=0, b=5 -> done one cycle after edge N+1, hilo=0. Without the macro: the same stimulus gives done one cycle after edge N+32.

Source files
------------

// File: rtl/muldiv_hilo_64_if.sv
// Request/response bundle between the EXP6 datapath and the HI/LO multiply/divide unit.
interface muldiv_hilo_64_if #(
  parameter int unsigned DW = 32
);
  logic            start;
  logic [1:0]      op;
  logic [DW-1:0]   a;
  logic [DW-1:0]   b;
  logic            hi_we;
  logic            lo_we;
  logic [DW-1:0]   wdata;
  logic            busy;
  logic            done;
  logic [2*DW-1:0] hilo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hilo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hilo
  );
endinterface

// File: rtl/muldiv_hilo_64.sv
// Iterative mult/multu/div/divu unit owning the HI/LO pair; one shift step per cycle.
// Optional MULDIV_EARLY_ZERO_EN: trivially-zero operations finish after a single busy cycle.
module muldiv_hilo_64 #(
  parameter int unsigned DW   = 32,
  parameter int unsigned ITER = 32
) (
  input logic              clk,
  input logic              rst,
  muldiv_hilo_64_if.slave  bus
);
  localparam int unsigned PW = 2 * DW;
  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] p_q, p_d;
  logic [PW-1:0] hilo_q, hilo_d;
  logic [DW-1:0] opnd_q, opnd_d;
  logic          div_q, div_d;
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;
  logic          bzero_q, bzero_d;
  logic          early_q, early_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          sgn_c;
  logic          early_c;
  logic [DW-1:0] abs_a_c, abs_b_c;
  logic [DW:0]   msum_c, rsh_c;
  logic          ge_c;
  logic [PW-1:0] p_mul_c, p_div_c, p_step_c;
  logic [DW-1:0] quo_c, rem_c;
  logic [PW-1:0] res_c;

  assign sgn_c   = bus.op[0];
  assign abs_a_c = (sgn_c && bus.a[DW-1]) ? DW'(-bus.a) : bus.a;
  assign abs_b_c = (sgn_c && bus.b[DW-1]) ? DW'(-bus.b) : bus.b;

`ifdef MULDIV_EARLY_ZERO_EN
  assign early_c = bus.op[1] ? ((bus.a == '0) && (bus.b != '0))
                             : ((bus.a == '0) || (bus.b == '0));
`else
  assign early_c = 1'b0;
`endif

  // Shift-add multiply step: upper half accumulates, multiplier shifts out of the low end.
  assign msum_c  = {1'b0, p_q[PW-1:DW]} + (p_q[0] ? {1'b0, opnd_q} : '0);
  assign p_mul_c = {msum_c, p_q[DW-1:1]};

  // Restoring divide step: partial remainder in the upper half, quotient builds in the lower.
  assign rsh_c   = {p_q[PW-1:DW], p_q[DW-1]};
  assign ge_c    = (rsh_c >= {1'b0, opnd_q});
  assign p_div_c = ge_c ? {DW'(rsh_c - {1'b0, opnd_q}), p_q[DW-2:0], 1'b1}
                        : {rsh_c[DW-1:0], p_q[DW-2:0], 1'b0};

  assign p_step_c = div_q ? p_div_c : p_mul_c;

  // Sign correction of the final step; divide-by-zero forces an all-ones quotient.
  assign quo_c = bzero_q ? '1 : (negq_q ? DW'(-p_step_c[DW-1:0]) : p_step_c[DW-1:0]);
  assign rem_c = negr_q ? DW'(-p_step_c[PW-1:DW]) : p_step_c[PW-1:DW];
  assign res_c = div_q ? {rem_c, quo_c} : (negq_q ? PW'(-p_step_c) : p_step_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      hilo_q  <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      bzero_q <= 1'b0;
      early_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      hilo_q  <= hilo_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      bzero_q <= bzero_d;
      early_q <= early_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    hilo_d  = hilo_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    bzero_d = bzero_q;
    early_d = early_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          div_d   = bus.op[1];
          negq_d  = sgn_c && (bus.a[DW-1] ^ bus.b[DW-1]);
          negr_d  = sgn_c && bus.a[DW-1];
          bzero_d = (bus.b == '0);
          early_d = early_c;
          opnd_d  = bus.op[1] ? abs_b_c : abs_a_c;
          p_d     = bus.op[1] ? {{DW{1'b0}}, abs_a_c} : {{DW{1'b0}}, abs_b_c};
          busy_d  = 1'b1;
        end else begin
          if (bus.hi_we) hilo_d[PW-1:DW] = bus.wdata;
          if (bus.lo_we) hilo_d[DW-1:0]  = bus.wdata;
        end
      end
      RUN: begin
        if (early_q) begin
          hilo_d  = '0;
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          p_d   = p_step_c;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) begin
            hilo_d  = res_c;
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hilo = hilo_q;
endmodule

// File: tb/tb_muldiv_hilo_64.sv
// Directed bench for muldiv_hilo_64; a negedge monitor scores every done pulse against a queue.
module tb_muldiv_hilo_64;
  localparam int unsigned DW   = 32;
  localparam int unsigned ITER = 32;
`ifdef MULDIV_EARLY_ZERO_EN
  localparam int unsigned LAT_Z = 1;
`else
  localparam int unsigned LAT_Z = ITER;
`endif

  typedef struct {
    logic [63:0] hilo;
    int unsigned cyc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];

  muldiv_hilo_64_if #(.DW(DW)) bus ();
  muldiv_hilo_64 #(.DW(DW), .ITER(ITER)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check64(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check64({e.name, " done_cycle"}, 64'(cyc), 64'(e.cyc));
        check64({e.name, " hilo"}, bus.hilo, e.hilo);
      end
    end
  end

  task automatic run_op(string name, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                        logic [63:0] exp, int unsigned lat, logic [63:0] hold,
                        bit disturb, bit we_with_start);
    int unsigned busy_cnt;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    if (we_with_start) begin
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
    end
    @(posedge clk); #1;
    sb_q.push_back('{exp, cyc + lat, name});
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check64({name, " hold"}, bus.hilo, hold);
    busy_cnt = 0;
    for (int i = 0; i < int'(ITER) + 8; i++) begin
      if (!bus.busy) break;
      busy_cnt++;
      if (disturb) begin
        if (i == 5) begin
          bus.start = 1'b1;
          bus.hi_we = 1'b1;
          bus.wdata = 32'h0000_1234;
        end else begin
          bus.start = 1'b0;
          bus.hi_we = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    check64({name, " busy_cycles"}, 64'(busy_cnt), 64'(lat));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish by 100000 expected earlier end");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    rst       = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check64("rst_hilo", bus.hilo, 64'h0);
    check64("rst_busy", 64'(bus.busy), 64'h0);
    check64("rst_done", 64'(bus.done), 64'h0);
    rst = 1'b0;

    run_op("multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, ITER, 64'h0, 0, 0);
    run_op("mult_neg",   2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, ITER, 64'hFFFF_FFFE_0000_0001, 0, 0);
    run_op("div_neg",    2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, ITER, 64'hFFFF_FFFF_FFFF_FFEB, 0, 0);
    run_op("divu_by0",   2'b10, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF, ITER, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0);
    run_op("div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, ITER, 64'h0000_0064_FFFF_FFFF, 0, 0);
    run_op("div_by0_ng", 2'b11, 32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF, ITER, 64'h0000_0000_8000_0000, 0, 0);
    run_op("divu_rem",   2'b10, 32'd100,       32'd7,         64'h0000_0002_0000_000E, ITER, 64'hFFFF_FFFB_FFFF_FFFF, 0, 0);
    run_op("div_pos_ng", 2'b11, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, ITER, 64'h0000_0002_0000_000E, 0, 0);
    run_op("mult_minmin",2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, ITER, 64'h0000_0001_FFFF_FFFD, 0, 0);
    run_op("multu_dist", 2'b00, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, ITER, 64'h4000_0000_0000_0000, 1, 0);

    // mthi in IDLE touches only HI and never pulses done
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    check64("mthi_hilo", bus.hilo, 64'h0000_1234_2345_6780);
    check64("mthi_done", 64'(bus.done), 64'h0);
    check64("mthi_busy", 64'(bus.busy), 64'h0);

    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check64("mthilo_hilo", bus.hilo, 64'hCAFE_F00D_CAFE_F00D);

    run_op("start_wins", 2'b10, 32'd100, 32'd7, 64'h0000_0002_0000_000E, ITER, 64'hCAFE_F00D_CAFE_F00D, 0, 1);

    // Asynchronous reset in cycle 10 of a run aborts it without a result
    bus.op    = 2'b00;
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'hFFFF_FFFF;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check64("arst_hilo", bus.hilo, 64'h0);
    check64("arst_busy", 64'(bus.busy), 64'h0);
    check64("arst_done", 64'(bus.done), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("after_rst",  2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, ITER,  64'h0, 0, 0);
    run_op("multu_zero", 2'b00, 32'd0,         32'd5,         64'h0,                   LAT_Z, 64'hFFFF_FFFF_FFFF_FFEB, 0, 0);
    run_op("mtlo_prep",  2'b00, 32'd3,         32'd5,         64'h0000_0000_0000_000F, ITER,  64'h0, 0, 0);
    run_op("divu_zero",  2'b10, 32'd0,         32'd3,         64'h0,                   LAT_Z, 64'h0000_0000_0000_000F, 0, 0);
    run_op("div_0by0",   2'b11, 32'd0,         32'd0,         64'h0000_0000_FFFF_FFFF, ITER,  64'h0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check64("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
